pdp1_typewriter_pacer: RTL and testbench

//  Sits between the PDP-1 typewriter IOT (tyo) and the VGA typewriter renderer.

---
 rtl/pdp1_typewriter_pacer.sv | 149 ++++++++++++++
 tb/tb_pdp1_typewriter_pacer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp1_typewriter_pacer.sv
// rtl/pdp1_typewriter_pacer.sv - FIODEC character FIFO and typewriter-speed strobe pacer
// Build option: define TW_FAST_SHIFT_EN to end case-shift (072/074) periods right after the strobe.

module pdp1_typewriter_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [5:0]    push_tdata,
  input  logic          pop,
  output logic [5:0]    pop_tdata,
  output logic [AW:0]   count
);
  logic [5:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // An empty FIFO hands a same-cycle push straight through to the reader.
  assign pop_tdata = (count == '0) ? push_tdata : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module pdp1_typewriter_pacer #(
  parameter int FIFO_AW     = 4,
  parameter int CHAR_PERIOD = 5000000,
  parameter int STROBE_LEN  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         pdp_char_in,
  input  logic               pdp_char_valid,
  output logic               pdp_char_ready,
  input  logic               flush,
  output logic [6:0]         tw_char_out,
  output logic               tw_strobe,
  output logic               tw_busy,
  output logic               tw_done,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_PACE   = 2'd3;

  localparam logic [31:0] PERIOD_LAST = 32'(CHAR_PERIOD - 1);
  localparam logic [31:0] STROBE_LAST = 32'(STROBE_LEN);

  logic [1:0]  state;
  logic [31:0] pcnt;
  logic [31:0] last_cnt;
  logic [5:0]  head;
  logic        push_ok;
  logic        have_next;
  logic        period_end;
  logic        load_go;

  assign pdp_char_ready = ~fifo_count[FIFO_AW];
  assign push_ok        = pdp_char_valid & pdp_char_ready & ~flush;

`ifdef TW_FAST_SHIFT_EN
  localparam logic [31:0] SHIFT_LAST = 32'(STROBE_LEN + 1);
  logic shift_code;

  // A case shift moves no carriage, so its period ends just after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       shift_code <= 1'b0;
    else if (load_go) shift_code <= (head == 6'o72) || (head == 6'o74);
  end

  assign last_cnt = shift_code ? SHIFT_LAST : PERIOD_LAST;
`else
  assign last_cnt = PERIOD_LAST;
`endif

  assign period_end = (state == S_PACE) && (pcnt == last_cnt);
  assign have_next  = ~flush & ((fifo_count != '0) | push_ok);
  assign load_go    = ((state == S_IDLE) && (fifo_count != '0) && !flush) ||
                      (period_end && have_next);

  pdp1_typewriter_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push_ok),
    .push_tdata (pdp_char_in),
    .pop        (load_go),
    .pop_tdata  (head),
    .count      (fifo_count)
  );

  // pcnt is zero in the LOAD cycle, so strobe rises land exactly one period apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pcnt        <= '0;
      tw_char_out <= '0;
    end else begin
      if (load_go) begin
        pcnt        <= '0;
        tw_char_out <= {1'b0, head};
      end else if (state != S_IDLE) begin
        pcnt <= pcnt + 32'd1;
      end
      case (state)
        S_IDLE:   if (load_go) state <= S_LOAD;
        S_LOAD:   state <= S_STROBE;
        S_STROBE: if (pcnt == STROBE_LAST) state <= S_PACE;
        S_PACE:   if (period_end) state <= load_go ? S_LOAD : S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    overflow <= 1'b0;
    else if (flush)                                overflow <= 1'b0;
    else if (pdp_char_valid && !pdp_char_ready)    overflow <= 1'b1;
  end

  assign tw_strobe = (state == S_STROBE);
  assign tw_done   = period_end;
  assign tw_busy   = (state != S_IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_pdp1_typewriter_pacer.sv
// tb/tb_pdp1_typewriter_pacer.sv - randomized lockstep bench for pdp1_typewriter_pacer
// Queue-and-timer reference model plus directed timing scenarios.

module tb_pdp1_typewriter_pacer;
  localparam int AW    = 2;
  localparam int CP    = 20;
  localparam int SL    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] pdp_char_in;
  logic       pdp_char_valid;
  logic       pdp_char_ready;
  logic       flush;
  logic [6:0] tw_char_out;
  logic       tw_strobe;
  logic       tw_busy;
  logic       tw_done;
  logic       overflow;
  logic [AW:0] fifo_count;

  always #5 clk = ~clk;

  pdp1_typewriter_pacer #(.FIFO_AW(AW), .CHAR_PERIOD(CP), .STROBE_LEN(SL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pdp_char_in    (pdp_char_in),
    .pdp_char_valid (pdp_char_valid),
    .pdp_char_ready (pdp_char_ready),
    .flush          (flush),
    .tw_char_out    (tw_char_out),
    .tw_strobe      (tw_strobe),
    .tw_busy        (tw_busy),
    .tw_done        (tw_done),
    .overflow       (overflow),
    .fifo_count     (fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  logic prev_strobe = 1'b0;
  int         rise_cyc[$];
  logic [5:0] rise_chr[$];

  // Reference model: queued codes plus cycles elapsed since the current character was loaded.
  logic [5:0] m_q[$];
  int         m_phase;
  logic [5:0] m_cur;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_period(input logic [5:0] c);
`ifdef TW_FAST_SHIFT_EN
    if (c == 6'o72 || c == 6'o74) return SL + 2;
`endif
    return CP;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_phase = -1;
    m_cur   = '0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void m_edge(input logic v, input logic [5:0] d, input logic f);
    logic acc, fin, start;
    acc = v && (m_q.size() < DEPTH) && !f;
    fin = (m_phase >= 0) && (m_phase == m_period(m_cur) - 1);
    if (f) m_ovf = 1'b0;
    else if (v && m_q.size() >= DEPTH) m_ovf = 1'b1;
    if (m_phase < 0) start = !f && (m_q.size() > 0);
    else             start = fin && !f && ((m_q.size() > 0) || acc);
    if (acc) m_q.push_back(d);
    if (f)   m_q.delete();
    if (start) begin
      m_cur   = m_q.pop_front();
      m_phase = 0;
    end else if (fin) begin
      m_phase = -1;
    end else if (m_phase >= 0) begin
      m_phase++;
    end
  endfunction

  task automatic compare_model();
    check("char_out", 32'(tw_char_out), 32'({1'b0, m_cur}));
    check("strobe",   32'(tw_strobe),   32'(m_phase >= 1 && m_phase <= SL));
    check("done",     32'(tw_done),     32'(m_phase >= 0 && m_phase == m_period(m_cur) - 1));
    check("busy",     32'(tw_busy),     32'(m_phase >= 0 || m_q.size() != 0));
    check("ready",    32'(pdp_char_ready), 32'(m_q.size() < DEPTH));
    check("count",    32'(fifo_count),  32'(m_q.size()));
    check("overflow", 32'(overflow),    32'(m_ovf));
  endtask

  task automatic step(input logic v, input logic [5:0] d, input logic f);
    pdp_char_valid = v;
    pdp_char_in    = d;
    flush          = f;
    compare_model();
    if (tw_strobe && !prev_strobe) begin
      rise_cyc.push_back(cyc);
      rise_chr.push_back(tw_char_out[5:0]);
    end
    if (tw_done) n_done++;
    prev_strobe = tw_strobe;
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_edge(v, d, f);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (tw_busy && k < limit) begin
      step(1'b0, 6'h0, 1'b0);
      k++;
    end
    if (tw_busy) check("wait_idle_timeout", 32'(tw_busy), 32'(0));
  endtask

  task automatic wait_strobe(input int limit);
    int k = 0;
    while (!tw_strobe && k < limit) begin
      step(1'b0, 6'h0, 1'b0);
      k++;
    end
    if (!tw_strobe) check("wait_strobe_timeout", 32'(tw_strobe), 32'(1));
  endtask

  logic       s_str [0:24];
  logic       s_done[0:24];
  logic       s_busy[0:24];
  logic [6:0] s_chr [0:24];
  int         base;
  int         done0;

  initial begin
    rst_n = 1'b0; pdp_char_valid = 1'b0; pdp_char_in = '0; flush = 1'b0;
    m_reset();
    @(negedge clk);
    step(1'b0, 6'h0, 1'b0);
    step(1'b0, 6'h0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 6'h0, 1'b0);

    // single character into an empty FIFO: cycle-exact timing
    step(1'b1, 6'h21, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, 6'h0, 1'b0);
      s_str[k] = tw_strobe; s_done[k] = tw_done; s_busy[k] = tw_busy; s_chr[k] = tw_char_out;
    end
    check("t1_char_c1",   32'(s_chr[1]),   32'h21);
    check("t1_strobe_c1", 32'(s_str[1]),   32'(0));
    check("t1_strobe_c2", 32'(s_str[2]),   32'(1));
    check("t1_strobe_c5", 32'(s_str[5]),   32'(1));
    check("t1_strobe_c6", 32'(s_str[6]),   32'(0));
    check("t1_done_c19",  32'(s_done[19]), 32'(0));
    check("t1_done_c20",  32'(s_done[20]), 32'(1));
    check("t1_busy_c20",  32'(s_busy[20]), 32'(1));
    check("t1_busy_c21",  32'(s_busy[21]), 32'(0));

    // five back-to-back pushes: all accepted, paced in order
    wait_idle(200);
    base = rise_cyc.size();
    for (int i = 0; i < 5; i++) step(1'b1, 6'(6'h11 + i), 1'b0);
    check("t2_ready_full", 32'(pdp_char_ready), 32'(0));
    check("t2_no_ovf",     32'(overflow),       32'(0));
    wait_idle(200);
    check("t2_nrise", 32'(rise_cyc.size() - base), 32'(5));
    if (rise_cyc.size() - base == 5) begin
      for (int i = 0; i < 5; i++) check("t2_order", 32'(rise_chr[base + i]), 32'(6'h11 + i));
      for (int i = 0; i < 4; i++) check("t2_gap", 32'(rise_cyc[base + i + 1] - rise_cyc[base + i]), 32'(CP));
    end

    // overflow while full, then flush
    base = rise_cyc.size();
    for (int i = 0; i < 5; i++) step(1'b1, 6'(6'h31 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'(6'h3A + i), 1'b0);
    check("t3_ovf_set", 32'(overflow), 32'(1));
    step(1'b0, 6'h0, 1'b0);
    step(1'b0, 6'h0, 1'b0);
    check("t3_ovf_sticky", 32'(overflow), 32'(1));
    step(1'b0, 6'h0, 1'b1);
    check("t3_ovf_clear", 32'(overflow),   32'(0));
    check("t3_count0",    32'(fifo_count), 32'(0));
    wait_idle(200);
    check("t3_nrise", 32'(rise_cyc.size() - base), 32'(1));
    for (int i = base; i < rise_cyc.size(); i++)
      check("t3_dropped", 32'(rise_chr[i] >= 6'h3A && rise_chr[i] <= 6'h3C), 32'(0));

    // flush plus push while a character is in flight
    base  = rise_cyc.size();
    done0 = n_done;
    step(1'b1, 6'h15, 1'b0);
    wait_strobe(10);
    step(1'b1, 6'h2A, 1'b1);
    wait_idle(100);
    check("t5_nrise", 32'(rise_cyc.size() - base), 32'(1));
    if (rise_cyc.size() > base) check("t5_char", 32'(rise_chr[base]), 32'h15);
    check("t5_done", 32'(n_done - done0), 32'(1));

    // upper-case shift followed by a printing code
    base = rise_cyc.size();
    step(1'b1, 6'o74, 1'b0);
    step(1'b1, 6'h05, 1'b0);
    wait_idle(200);
    check("t6_nrise", 32'(rise_cyc.size() - base), 32'(2));
    if (rise_cyc.size() - base == 2)
`ifdef TW_FAST_SHIFT_EN
      check("t6_gap", 32'(rise_cyc[base + 1] - rise_cyc[base]), 32'(SL + 2));
`else
      check("t6_gap", 32'(rise_cyc[base + 1] - rise_cyc[base]), 32'(CP));
`endif

    // randomized traffic against the model
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) == 0, 6'($urandom), $urandom_range(0, 49) == 0);

    // asynchronous reset in the middle of a strobe
    wait_idle(200);
    step(1'b1, 6'h33, 1'b1);
    step(1'b1, 6'h33, 1'b0);
    step(1'b1, 6'h34, 1'b0);
    wait_strobe(10);
    #2 rst_n = 1'b0;
    #1;
    check("t4_strobe", 32'(tw_strobe),      32'(0));
    check("t4_char",   32'(tw_char_out),    32'(0));
    check("t4_busy",   32'(tw_busy),        32'(0));
    check("t4_done",   32'(tw_done),        32'(0));
    check("t4_count",  32'(fifo_count),     32'(0));
    check("t4_ready",  32'(pdp_char_ready), 32'(1));
    check("t4_ovf",    32'(overflow),       32'(0));
    m_reset();
    prev_strobe = 1'b0;
    @(negedge clk);
    step(1'b0, 6'h0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 6'h0, 1'b0);
    check("t4_empty_after", 32'(fifo_count), 32'(0));

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 2) == 0, 6'($urandom), $urandom_range(0, 59) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
